// File: rtl/bus_xfer_seq.sv
// rtl/bus_xfer_seq.sv - register-transfer control sequencer for a single-bus datapath
// Issues one-hot register drive/load strobes for MOVE, ALU and IMM operations.
module bus_xfer_seq (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  input  logic [3:0]  dst,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_ALU  = 2'b01;
  localparam logic [1:0] OP_IMM  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] srca_q, srca_d;
  logic [3:0] srcb_q, srcb_d;
  logic [3:0] dst_q, dst_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          srca_d  = srcA;
          srcb_d  = srcB;
          dst_d   = dst;
          state_d = S_T0;
        end
      end
      S_T0:    state_d = (op_q == OP_ALU) ? S_T1 : S_DONE;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      srca_q  <= 4'd0;
      srcb_q  <= 4'd0;
      dst_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      dst_q   <= dst_d;
    end
  end

  // Strobes depend only on registered state and latched fields, so the
  // bus drivers never see a glitch from the request inputs.
  always_comb begin
    Rout    = 16'd0;
    Rin     = 16'd0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Cout    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_T0: begin
        case (op_q)
          OP_MOVE: begin
            Rout = 16'd1 << srca_q;
            Rin  = 16'd1 << dst_q;
          end
          OP_ALU: begin
            Rout = 16'd1 << srca_q;
            Yin  = 1'b1;
          end
          OP_IMM: begin
            Cout = 1'b1;
            Rin  = 16'd1 << dst_q;
          end
          default: ;
        endcase
      end
      S_T1: begin
        Rout = 16'd1 << srcb_q;
        Zin  = 1'b1;
      end
      S_T2: begin
        Zlowout = 1'b1;
        Rin     = 16'd1 << dst_q;
      end
      S_DONE: begin
        done = 1'b1;
        err  = (op_q == OP_RSV);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// tb/tb_bus_xfer_seq.sv - self-checking bench for bus_xfer_seq
// Table vectors, hand-written corner sequences and a cycle-list reference model.
module tb_bus_xfer_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  srcA, srcB, dst;
  logic [15:0] Rout, Rin;
  logic        Yin, Zin, Zlowout, Cout, busy, done, err;

  bus_xfer_seq dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .dst(dst),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef logic [38:0] vec_t;
  vec_t dut_vec;
  assign dut_vec = {Rout, Rin, Yin, Zin, Zlowout, Cout, busy, done, err};

  int n_tests = 0;
  int n_fail  = 0;
  vec_t exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  a, b, d;
    logic [15:0] t0_rout, t0_rin;
    logic        t0_yin, t0_cout;
    int          lat;
    logic        err;
  } rec_t;
  rec_t tbl[5];

  function automatic vec_t mk(input logic [15:0] ro, input logic [15:0] ri,
                              input logic y, input logic z, input logic zl,
                              input logic c, input logic b, input logic dn,
                              input logic e);
    return {ro, ri, y, z, zl, c, b, dn, e};
  endfunction

  // Reference: each operation is a fixed list of per-cycle bus actions,
  // starting at the cycle after acceptance and ending with one idle cycle.
  function automatic void build(input logic [1:0] o, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] d);
    logic [15:0] oa, ob, od;
    oa = 16'd1 << a;
    ob = 16'd1 << b;
    od = 16'd1 << d;
    exp_q.delete();
    case (o)
      2'd0: exp_q.push_back(mk(oa, od, 0, 0, 0, 0, 1, 0, 0));
      2'd1: begin
        exp_q.push_back(mk(oa, 16'd0, 1, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(ob, 16'd0, 0, 1, 0, 0, 1, 0, 0));
        exp_q.push_back(mk(16'd0, od, 0, 0, 1, 0, 1, 0, 0));
      end
      2'd2: exp_q.push_back(mk(16'd0, od, 0, 0, 0, 1, 1, 0, 0));
      default: exp_q.push_back(mk(16'd0, 16'd0, 0, 0, 0, 0, 1, 0, 0));
    endcase
    exp_q.push_back(mk(16'd0, 16'd0, 0, 0, 0, 0, 1, 1, (o == 2'd3)));
    exp_q.push_back(mk(16'd0, 16'd0, 0, 0, 0, 0, 0, 0, 0));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input vec_t want);
    n_tests++;
    if (dut_vec !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, dut_vec, want);
    end
    n_tests++;
    if (!$onehot0({Rout, Zlowout, Cout}) || !$onehot0(Rin)) begin
      n_fail++;
      $display("FAIL onehot %s: Rout=%h Zlowout=%b Cout=%b Rin=%h required one-hot or zero",
               name, Rout, Zlowout, Cout, Rin);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Start an operation; fields are scrambled after acceptance to show they are latched.
  task automatic run_txn(input logic [1:0] o, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] d, input string nm);
    start = 1'b1;
    op = o; srcA = a; srcB = b; dst = d;
    build(o, a, b, d);
    step();
    start = 1'b0;
    op = 2'($urandom); srcA = 4'($urandom); srcB = 4'($urandom); dst = 4'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s c%0d", nm, i), exp_q[i]);
      step();
    end
  endtask

  localparam vec_t ZERO = 39'd0;

  initial begin
    int cnt;
    tbl[0] = '{2'd0, 4'd3,  4'd0, 4'd7,  16'h0008, 16'h0080, 1'b0, 1'b0, 2, 1'b0};
    tbl[1] = '{2'd1, 4'd2,  4'd5, 4'd9,  16'h0004, 16'h0000, 1'b1, 1'b0, 4, 1'b0};
    tbl[2] = '{2'd2, 4'd0,  4'd0, 4'd0,  16'h0000, 16'h0001, 1'b0, 1'b1, 2, 1'b0};
    tbl[3] = '{2'd3, 4'd1,  4'd2, 4'd3,  16'h0000, 16'h0000, 1'b0, 1'b0, 2, 1'b1};
    tbl[4] = '{2'd0, 4'd12, 4'd0, 4'd12, 16'h1000, 16'h1000, 1'b0, 1'b0, 2, 1'b0};

    clear = 1'b0; start = 1'b0; op = 2'd0; srcA = 4'd0; srcB = 4'd0; dst = 4'd0;
    step();
    step();
    check("reset", ZERO);

    start = 1'b1; op = 2'd1; srcA = 4'd4;
    step();
    check("reset_over_start", ZERO);
    start = 1'b0;
    clear = 1'b1;
    step();
    check("idle_after_reset", ZERO);

    for (int t = 0; t < 5; t++) begin
      start = 1'b1;
      op = tbl[t].op; srcA = tbl[t].a; srcB = tbl[t].b; dst = tbl[t].d;
      step();
      start = 1'b0;
      check_word($sformatf("tbl%0d t0 Rout", t), Rout, tbl[t].t0_rout);
      check_word($sformatf("tbl%0d t0 Rin", t), Rin, tbl[t].t0_rin);
      check_bit($sformatf("tbl%0d t0 Yin", t), Yin, tbl[t].t0_yin);
      check_bit($sformatf("tbl%0d t0 Cout", t), Cout, tbl[t].t0_cout);
      cnt = 1;
      while (!done && cnt < 10) begin
        step();
        cnt++;
      end
      n_tests++;
      if (cnt != tbl[t].lat) begin
        n_fail++;
        $display("FAIL tbl%0d latency: got %0d want %0d", t, cnt, tbl[t].lat);
      end
      check_bit($sformatf("tbl%0d err", t), err, tbl[t].err);
      step();
      check($sformatf("tbl%0d idle", t), ZERO);
    end

    run_txn(2'd1, 4'd2, 4'd5, 4'd9, "alu_ref");

    // Reset during T1 must abort without a done pulse.
    start = 1'b1; op = 2'd1; srcA = 4'd2; srcB = 4'd5; dst = 4'd9;
    step();
    start = 1'b0;
    check("abort t0", mk(16'h0004, 16'h0000, 1, 0, 0, 0, 1, 0, 0));
    step();
    check("abort t1", mk(16'h0020, 16'h0000, 0, 1, 0, 0, 1, 0, 0));
    clear = 1'b0;
    step();
    check("abort reset", ZERO);
    step();
    check("abort held", ZERO);
    clear = 1'b1;
    step();
    check("abort no done", ZERO);
    run_txn(2'd2, 4'd0, 4'd0, 4'd15, "after_abort");

    // Start held high: second op accepted only from IDLE.
    start = 1'b1; op = 2'd1; srcA = 4'd1; srcB = 4'd4; dst = 4'd6;
    build(2'd1, 4'd1, 4'd4, 4'd6);
    step();
    op = 2'd0; srcA = 4'd10; dst = 4'd11;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("b2b first c%0d", i), exp_q[i]);
      step();
    end
    start = 1'b0;
    check("b2b second t0", mk(16'h0400, 16'h0800, 0, 0, 0, 0, 1, 0, 0));
    step();
    check("b2b second done", mk(16'd0, 16'd0, 0, 0, 0, 0, 1, 1, 0));
    step();
    check("b2b second idle", ZERO);

    for (int r = 0; r < 60; r++) begin
      run_txn(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
